// File: rtl/dmem_lsu.sv
// Byte-addressed data memory with a load/store front end for the MEM stage; fixed read latency 1..4.
// Build option: define DMEM_MISALIGN_CHECK_EN to flag and suppress misaligned accesses (otherwise they are force-aligned).
module dmem_lsu #(
    parameter int XLEN    = 64,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_misalign,
    output logic            rsp_oob
);
    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);
    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = $clog2(LATENCY + 1);
    localparam int PW   = XLEN + 2;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;

    state_t          r_state, w_state_next;
    logic [CW-1:0]   r_cnt, w_cnt_next;
    logic            w_accept;

    logic [OFFW-1:0] w_off, w_off_eff, w_mask;
    logic [XLEN-1:0] w_widx;
    logic [AW-1:0]   w_idx;
    logic [1:0]      w_size_eff;
    logic [3:0]      w_nbytes;
    logic            w_mis, w_oob, w_fault;
    logic [NB-1:0]   w_be;
    logic [XLEN-1:0] w_wdata_sh;

    logic [XLEN-1:0] r_mem [DEPTH];
    logic [XLEN-1:0] r_rd_word;
    logic [OFFW-1:0] r_off;
    logic [1:0]      r_size;
    logic            r_uns, r_we, r_mis, r_oob;

    logic [XLEN-1:0] w_shift, w_keep, w_ext, w_fmt;
    logic [6:0]      w_nbits;
    logic            w_sign;
    logic [PW-1:0]   w_pipe [LATENCY];

    // Request decode: word index, lane offset, fault flags, lane enables
    always_comb begin
        w_off  = req_addr[OFFW-1:0];
        w_widx = req_addr >> OFFW;
        w_idx  = w_widx[AW-1:0];
        w_oob  = (w_widx >= XLEN'(DEPTH));
`ifdef DMEM_MISALIGN_CHECK_EN
        w_size_eff = req_size;
        w_nbytes   = 4'd1 << req_size;
        w_mask     = OFFW'(w_nbytes - 4'd1);
        w_mis      = ((XLEN == 32) && (req_size == 2'b11)) || ((w_off & w_mask) != '0);
        w_off_eff  = w_off;
`else
        w_size_eff = ((XLEN == 32) && (req_size == 2'b11)) ? 2'b10 : req_size;
        w_nbytes   = 4'd1 << w_size_eff;
        w_mask     = OFFW'(w_nbytes - 4'd1);
        w_mis      = 1'b0;
        w_off_eff  = w_off & ~w_mask;
`endif
        w_fault    = w_mis | w_oob;
        w_wdata_sh = req_wdata << {w_off_eff, 3'b000};
    end

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            assign w_be[gi] = (4'(gi) >= 4'(w_off_eff)) && (4'(gi) < (4'(w_off_eff) + w_nbytes));
        end
    endgenerate

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_IDLE, S_RESP: begin
                w_state_next = S_IDLE;
                if (w_accept) begin
                    if (LATENCY == 1) begin
                        w_state_next = S_RESP;
                    end else begin
                        w_state_next = S_WAIT;
                        w_cnt_next   = CW'(LATENCY - 1);
                    end
                end
            end
            S_WAIT: begin
                w_cnt_next = r_cnt - CW'(1);
                if (r_cnt == CW'(1)) w_state_next = S_RESP;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        req_ready = rst && ((r_state == S_IDLE) || (r_state == S_RESP));
        rsp_valid = (r_state == S_RESP);
    end

    assign w_accept = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (w_accept && req_we && !w_fault) begin
            for (int b = 0; b < NB; b++) begin
                if (w_be[b]) r_mem[w_idx][b*8 +: 8] <= w_wdata_sh[b*8 +: 8];
            end
        end
    end

    // Registered read port plus the request attributes needed to shape the response
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rd_word <= '0;
            r_off     <= '0;
            r_size    <= '0;
            r_uns     <= 1'b0;
            r_we      <= 1'b0;
            r_mis     <= 1'b0;
            r_oob     <= 1'b0;
        end else if (w_accept) begin
            r_rd_word <= r_mem[w_idx];
            r_off     <= w_off_eff;
            r_size    <= w_size_eff;
            r_uns     <= req_unsigned;
            r_we      <= req_we;
            r_mis     <= w_mis;
            r_oob     <= w_oob;
        end
    end

    always_comb begin
        w_shift = r_rd_word >> {r_off, 3'b000};
        w_nbits = 7'd8 << r_size;
        w_keep  = ~({XLEN{1'b1}} << w_nbits);
        case (r_size)
            2'b00:   w_sign = ~r_uns & w_shift[7];
            2'b01:   w_sign = ~r_uns & w_shift[15];
            2'b10:   w_sign = ~r_uns & w_shift[31];
            default: w_sign = ~r_uns & w_shift[XLEN-1];
        endcase
        w_ext = (w_shift & w_keep) | ({XLEN{w_sign}} & ~w_keep);
        w_fmt = (r_we || r_mis || r_oob) ? '0 : w_ext;
    end

    // Stage 0 only changes on accept, and accepts are >= LATENCY apart, so a free-running
    // shift keeps the last stage steady between responses.
    assign w_pipe[0] = {r_mis, r_oob, w_fmt};
    generate
        for (gi = 1; gi < LATENCY; gi++) begin : g_stage
            logic [PW-1:0] r_stage;
            always_ff @(posedge clk) begin
                if (!rst) r_stage <= '0;
                else      r_stage <= w_pipe[gi-1];
            end
            assign w_pipe[gi] = r_stage;
        end
    endgenerate

    assign {rsp_misalign, rsp_oob, rsp_rdata} = w_pipe[LATENCY-1];
endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: one LATENCY=1 and one LATENCY=3 instance checked against a byte-array model.
module tb_dmem_lsu;
    localparam int XLEN  = 64;
    localparam int DEPTH = 1024;
    localparam int LB    = 3;
    localparam int BWORDS = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        a_valid, a_ready, a_we, a_uns, a_rvalid, a_mis, a_oob;
    logic [1:0]  a_size;
    logic [63:0] a_addr, a_wdata, a_rdata;
    logic        b_valid, b_ready, b_we, b_uns, b_rvalid, b_mis, b_oob;
    logic [1:0]  b_size;
    logic [63:0] b_addr, b_wdata, b_rdata;

    dmem_lsu #(.XLEN(XLEN), .DEPTH(DEPTH), .LATENCY(1)) u_dut_a (
        .clk(clk), .rst(rst), .req_valid(a_valid), .req_ready(a_ready), .req_we(a_we),
        .req_size(a_size), .req_unsigned(a_uns), .req_addr(a_addr), .req_wdata(a_wdata),
        .rsp_valid(a_rvalid), .rsp_rdata(a_rdata), .rsp_misalign(a_mis), .rsp_oob(a_oob));

    dmem_lsu #(.XLEN(XLEN), .DEPTH(DEPTH), .LATENCY(LB)) u_dut_b (
        .clk(clk), .rst(rst), .req_valid(b_valid), .req_ready(b_ready), .req_we(b_we),
        .req_size(b_size), .req_unsigned(b_uns), .req_addr(b_addr), .req_wdata(b_wdata),
        .rsp_valid(b_rvalid), .rsp_rdata(b_rdata), .rsp_misalign(b_mis), .rsp_oob(b_oob));

    bit [7:0]    mem_a [DEPTH*8];
    bit [7:0]    mem_b [DEPTH*8];
    int          n_checks = 0;
    int          n_fail = 0;
    logic [63:0] b_last_rd = 64'd0;

    // Reference: plain byte-addressed memory, size in bytes, offset modulo 8
    task automatic model_access(input bit inst, input logic we, input logic [1:0] sz, input logic uns,
                                input logic [63:0] addr, input logic [63:0] wd,
                                output logic [63:0] rd, output logic mis, output logic oob);
        int nb, off, base;
        logic [63:0] widx, v;
        nb   = 1 << sz;
        off  = int'(addr % 64'd8);
        widx = addr / 64'd8;
        oob  = (widx >= 64'(DEPTH));
`ifdef DMEM_MISALIGN_CHECK_EN
        mis = (off % nb) != 0;
`else
        mis = 1'b0;
        off = off - (off % nb);
`endif
        rd = 64'd0;
        if (!mis && !oob) begin
            base = int'(widx) * 8 + off;
            if (we) begin
                for (int i = 0; i < nb; i++) begin
                    if (inst) mem_b[base+i] = wd[8*i +: 8];
                    else      mem_a[base+i] = wd[8*i +: 8];
                end
            end else begin
                v = 64'd0;
                for (int i = 0; i < nb; i++) v[8*i +: 8] = inst ? mem_b[base+i] : mem_a[base+i];
                if (!uns && nb < 8 && v[8*nb-1]) begin
                    for (int j = 8*nb; j < 64; j++) v[j] = 1'b1;
                end
                rd = v;
            end
        end
    endtask

    task automatic a_req(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                         input logic [63:0] addr, input logic [63:0] wd);
        logic [63:0] er;
        logic em, eo;
        model_access(1'b0, we, sz, uns, addr, wd, er, em, eo);
        a_valid = 1'b1; a_we = we; a_size = sz; a_uns = uns; a_addr = addr; a_wdata = wd;
        #1;
        n_checks++;
        if (a_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s ready: got %b want 1", tag, a_ready);
        end
        @(posedge clk); #1;
        a_valid = 1'b0;
        n_checks++;
        if (a_rvalid !== 1'b1 || a_rdata !== er || a_mis !== em || a_oob !== eo) begin
            n_fail++;
            $display("FAIL %s: got valid=%b rdata=%h mis=%b oob=%b, want valid=1 rdata=%h mis=%b oob=%b",
                     tag, a_rvalid, a_rdata, a_mis, a_oob, er, em, eo);
        end
        $display("[A] %s we=%0d size=%0d uns=%0d addr=%h wdata=%h -> rdata=%h mis=%b oob=%b",
                 tag, we, sz, uns, addr, wd, a_rdata, a_mis, a_oob);
    endtask

    task automatic b_req(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                         input logic [63:0] addr, input logic [63:0] wd);
        logic [63:0] er;
        logic em, eo;
        model_access(1'b1, we, sz, uns, addr, wd, er, em, eo);
        b_valid = 1'b1; b_we = we; b_size = sz; b_uns = uns; b_addr = addr; b_wdata = wd;
        #1;
        n_checks++;
        if (b_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s ready: got %b want 1", tag, b_ready);
        end
        @(posedge clk); #1;
        b_valid = 1'b0;
        for (int c = 1; c < LB; c++) begin
            n_checks++;
            if (b_rvalid !== 1'b0 || b_ready !== 1'b0 || b_rdata !== b_last_rd) begin
                n_fail++;
                $display("FAIL %s wait%0d: got valid=%b ready=%b rdata=%h, want valid=0 ready=0 rdata=%h",
                         tag, c, b_rvalid, b_ready, b_rdata, b_last_rd);
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (b_rvalid !== 1'b1 || b_ready !== 1'b1 || b_rdata !== er || b_mis !== em || b_oob !== eo) begin
            n_fail++;
            $display("FAIL %s: got valid=%b ready=%b rdata=%h mis=%b oob=%b, want valid=1 ready=1 rdata=%h mis=%b oob=%b",
                     tag, b_rvalid, b_ready, b_rdata, b_mis, b_oob, er, em, eo);
        end
        b_last_rd = er;
        $display("[B] %s we=%0d size=%0d uns=%0d addr=%h -> rdata=%h mis=%b oob=%b",
                 tag, we, sz, uns, addr, b_rdata, b_mis, b_oob);
    endtask

    task automatic test_power_on();
        @(posedge clk); #1;
        n_checks++;
        if (a_ready !== 1'b0 || a_rvalid !== 1'b0 || a_rdata !== 64'd0 || a_mis !== 1'b0 || a_oob !== 1'b0) begin
            n_fail++;
            $display("FAIL power_on: got ready=%b valid=%b rdata=%h mis=%b oob=%b, want all 0",
                     a_ready, a_rvalid, a_rdata, a_mis, a_oob);
        end
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic fill_zero();
        a_valid = 1'b1; a_we = 1'b1; a_size = 2'b11; a_uns = 1'b0; a_wdata = 64'd0;
        for (int w = 0; w < DEPTH; w++) begin
            a_addr = 64'(w) * 64'd8;
            @(posedge clk); #1;
        end
        a_valid = 1'b0; a_we = 1'b0;
        b_we = 1'b1; b_size = 2'b11; b_uns = 1'b0; b_wdata = 64'd0;
        for (int w = 0; w < BWORDS; w++) begin
            b_valid = 1'b1;
            b_addr  = 64'(w) * 64'd8;
            @(posedge clk); #1;
            b_valid = 1'b0;
            repeat (LB - 1) begin @(posedge clk); #1; end
        end
        b_we = 1'b0;
    endtask

    task automatic test_byte_load();
        a_req("byte_st",   1'b1, 2'b00, 1'b0, 64'h13, 64'h1122334455667780);
        a_req("byte_lds",  1'b0, 2'b00, 1'b0, 64'h13, 64'd0);
        a_req("byte_ldu",  1'b0, 2'b00, 1'b1, 64'h13, 64'd0);
        a_req("byte_ldd",  1'b0, 2'b11, 1'b0, 64'h10, 64'd0);
    endtask

    task automatic test_double_half();
        a_req("dbl_st",    1'b1, 2'b11, 1'b0, 64'h20, 64'h0123456789ABCDEF);
        a_req("half_ldu",  1'b0, 2'b01, 1'b1, 64'h22, 64'd0);
        a_req("half_lds",  1'b0, 2'b01, 1'b0, 64'h22, 64'd0);
        a_req("word_lds",  1'b0, 2'b10, 1'b0, 64'h24, 64'd0);
    endtask

    task automatic test_misalign();
        a_req("mis_pre",   1'b1, 2'b11, 1'b0, 64'h0, 64'h11223344F5667788);
        a_req("mis_word",  1'b0, 2'b10, 1'b0, 64'h6, 64'd0);
        a_req("mis_hst",   1'b1, 2'b01, 1'b0, 64'h3, 64'hAAAA_BBBB_CCCC_DDEE);
        a_req("mis_chk",   1'b0, 2'b11, 1'b0, 64'h0, 64'd0);
        a_req("mis_dbl",   1'b0, 2'b11, 1'b1, 64'h5, 64'd0);
    endtask

    task automatic test_oob();
        logic [63:0] top;
        top = 64'(DEPTH) * 64'd8;
        a_req("oob_ld",    1'b0, 2'b11, 1'b0, top, 64'd0);
        a_req("oob_st",    1'b1, 2'b11, 1'b0, top, 64'hFFFF_FFFF_FFFF_FFFF);
        a_req("oob_st2",   1'b1, 2'b00, 1'b0, top + 64'd8 * 64'd5 + 64'd1, 64'hFF);
        a_req("oob_mis",   1'b0, 2'b10, 1'b0, top + 64'd2, 64'd0);
        a_req("oob_w0",    1'b0, 2'b11, 1'b0, 64'h0, 64'd0);
        a_req("oob_w5",    1'b0, 2'b11, 1'b0, 64'h28, 64'd0);
        a_req("oob_wlast", 1'b0, 2'b11, 1'b0, top - 64'd8, 64'd0);
    endtask

    task automatic test_reset();
        a_req("rst_pre",   1'b0, 2'b11, 1'b0, 64'h20, 64'd0);
        rst = 1'b0;
        a_valid = 1'b1; a_we = 1'b1; a_size = 2'b11; a_addr = 64'h20; a_wdata = 64'hDEADBEEFCAFEF00D;
        #1;
        n_checks++;
        if (a_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_ready: got %b want 0", a_ready);
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if (a_ready !== 1'b0 || a_rvalid !== 1'b0 || a_rdata !== 64'd0 || a_mis !== 1'b0 ||
                a_oob !== 1'b0 || b_rvalid !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_hold%0d: got ready=%b valid=%b rdata=%h mis=%b oob=%b bvalid=%b, want all 0",
                         c, a_ready, a_rvalid, a_rdata, a_mis, a_oob, b_rvalid);
            end
        end
        a_valid = 1'b0; a_we = 1'b0;
        rst = 1'b1;
        b_last_rd = 64'd0;
        a_req("rst_nowr",  1'b0, 2'b11, 1'b0, 64'h20, 64'd0);
    endtask

    task automatic test_random_a();
        logic [63:0] addr;
        for (int t = 0; t < 48; t++) begin
            addr = 64'($urandom_range(BWORDS - 1)) * 64'd8 + 64'($urandom_range(7));
            if ($urandom_range(9) == 0) addr = addr + 64'(DEPTH) * 64'd8;
            a_req($sformatf("rnd_a%0d", t), 1'($urandom_range(1)), 2'($urandom_range(3)),
                  1'($urandom_range(1)), addr, {$urandom, $urandom});
        end
    endtask

    task automatic test_latency();
        b_req("lat_st",  1'b1, 2'b11, 1'b0, 64'h18, 64'h8877665544332211);
        b_req("lat_ld0", 1'b0, 2'b00, 1'b0, 64'h1F, 64'd0);
        b_req("lat_ld1", 1'b0, 2'b01, 1'b1, 64'h1A, 64'd0);
        b_req("lat_ld2", 1'b0, 2'b10, 1'b0, 64'h1C, 64'd0);
        b_req("lat_ld3", 1'b0, 2'b11, 1'b0, 64'h18, 64'd0);
        for (int t = 0; t < 12; t++) begin
            b_req($sformatf("rnd_b%0d", t), 1'($urandom_range(1)), 2'($urandom_range(3)),
                  1'($urandom_range(1)), 64'($urandom_range(BWORDS * 8 - 1)), {$urandom, $urandom});
        end
    endtask

    task automatic test_reset_wait();
        b_valid = 1'b1; b_we = 1'b0; b_size = 2'b11; b_uns = 1'b0; b_addr = 64'h18;
        @(posedge clk); #1;
        b_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        n_checks++;
        if (b_rdata !== 64'd0 || b_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL rstwait_clear: got valid=%b rdata=%h want valid=0 rdata=0", b_rvalid, b_rdata);
        end
        for (int c = 0; c < LB + 2; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if (b_rvalid !== 1'b0 || b_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL rstwait_idle%0d: got valid=%b ready=%b want valid=0 ready=1", c, b_rvalid, b_ready);
            end
        end
        b_last_rd = 64'd0;
        b_req("rstwait_after", 1'b0, 2'b11, 1'b0, 64'h18, 64'd0);
    endtask

    initial begin
        rst = 1'b0;
        a_valid = 1'b0; a_we = 1'b0; a_size = 2'b00; a_uns = 1'b0; a_addr = 64'd0; a_wdata = 64'd0;
        b_valid = 1'b0; b_we = 1'b0; b_size = 2'b00; b_uns = 1'b0; b_addr = 64'd0; b_wdata = 64'd0;
        test_power_on();
        fill_zero();
        test_byte_load();
        test_double_half();
        test_misalign();
        test_oob();
        test_reset();
        test_random_a();
        test_latency();
        test_reset_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Parametrised, byte-addressed data memory with a load/store front end for the pipelined core's MEM stage. Supports byte/half/word/double accesses, per-byte write lanes, and sign/zero extension on loads. Read latency is configurable, and accepted requests flow through a valid/ready handshake. Misaligned and out-of-range accesses are flagged on the response and never touch storage.

## Interface
- `XLEN`, 64: data and address width (32 or 64).
- `DEPTH`, 1024: number of XLEN-wide storage words. Byte capacity is `DEPTH*XLEN/8`.
- `LATENCY`, 1: cycles from request acceptance to response, legal range 1..4.

- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-low reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: block can accept a request this cycle.
- `req_we` input 1: 1 = store, 0 = load.
- `req_size` input 2: access size. 00 = byte, 01 = half, 10 = word, 11 = double (double is illegal when XLEN=32 and is treated as misaligned).
- `req_unsigned` input 1: load zero-extends when 1, sign-extends when 0.
- `req_addr` input XLEN: byte address.
- `req_wdata` input XLEN: store data, right-aligned (LSBs).
- `rsp_valid` output 1: one-cycle response pulse, no backpressure.
- `rsp_rdata` output XLEN: extended load data. 0 for stores and faults.
- `rsp_misalign` output 1: access was misaligned, or used an illegal size.
- `rsp_oob` output 1: address lies beyond the byte capacity.

## Operation
- Handshake: a request is accepted on a rising edge where `rst`=1, `req_valid`=1 and `req_ready`=1. Only one request is outstanding at a time.
- `req_ready` = 1 when nothing is outstanding, or when the outstanding request is responding this cycle (`rsp_valid`=1). It is 0 while `rst`=0.
- FSM:
  - IDLE: on accept with LATENCY=1, go to RESP. On accept with LATENCY>1, go to WAIT and load the down-counter with LATENCY-1.
  - WAIT: decrement the counter; go to RESP on the cycle after it reaches 1.
  - RESP: assert `rsp_valid`. Return to IDLE, or restart WAIT/RESP if a new request is accepted on the same edge.
- Addressing:
  - Word index = `req_addr >> log2(XLEN/8)`.
  - Lane offset = low `log2(XLEN/8)` address bits.
  - OOB when word index >= DEPTH.
- Misalign: the offset is not a multiple of the access size in bytes.
- Fault priority: misalign is reported first, and OOB is also reported if true. Both flags may be 1 together. A faulting access performs no write and returns `rsp_rdata`=0.
- Store: on the acceptance edge, write the low `size` bytes of `req_wdata` into the addressed lanes only. All other bytes of the word are unchanged.
- Load: the word is read on the acceptance edge. The addressed lanes are right-shifted and then sign- or zero-extended to XLEN. The result is held in a LATENCY-deep pipeline of registers.
- Storage is not cleared by reset. Simulation initialises all words to 0 at time zero.

## Timing
- A request accepted at edge k produces `rsp_valid`=1 for exactly one cycle, after edge k+LATENCY-1 and before edge k+LATENCY.
- Sustained throughput is one request per LATENCY cycles. At LATENCY=1 this allows back-to-back accepts on every edge.
- Read-after-write: a load accepted on the edge after a store to the same word returns the updated bytes.
- A store and a load are never accepted together, because there is one port.
- Reset values: `rsp_valid`=0, `rsp_rdata`=0, `rsp_misalign`=0, `rsp_oob`=0. The FSM returns to IDLE and the counter is 0.
- Reset mid-operation: the outstanding request is dropped with no response. A store presented while `rst`=0 is not written.
- Response fields are registered. They are valid only while `rsp_valid`=1, and hold their last value otherwise.

## Configuration
- `DMEM_MISALIGN_CHECK_EN` defined:
  - Misalignment is detected as described above.
  - Misaligned accesses are suppressed and flagged.
- `DMEM_MISALIGN_CHECK_EN` undefined:
  - The offset is forced aligned by clearing its low log2(size bytes) bits.
  - The access proceeds, provided it is in range.
  - `rsp_misalign` is tied to 0.
  - An illegal double access when XLEN=32 is executed as a word access.

## Test plan
- Reset: hold `rst`=0 for 3 cycles with `req_valid`=1. Required: `req_ready`=0, `rsp_valid`=0, and no writes occur.
- Byte store then signed load, LATENCY=1:
  - Store `req_size`=00 to address 0x13 with `req_wdata`=0x...80.
  - Then load signed byte from 0x13. Required: `rsp_rdata`=0xFFFF_FFFF_FFFF_FF80.
  - Then load unsigned. Required: 0x80.
  - Then load double from 0x10. Required: 0x0000_0000_8000_0000.
- Double store 0x0123_4567_89AB_CDEF at 0x20, then load half at 0x22. Required: 0x0000_0000_0000_89AB.
- Misalign: word load at 0x6. Required: `rsp_misalign`=1 and `rsp_rdata`=0. With the macro undefined, the access instead reads word offset 0x4 and the flag is 0.
- OOB: load at address 8*DEPTH. Required: `rsp_oob`=1 and `rsp_rdata`=0. A store to the same address leaves all memory unchanged.
- Latency: with LATENCY=3, issue loads continuously. Required:
  - `rsp_valid` pulses every 3 cycles.
  - `req_ready` is high only in IDLE or in response cycles.
  - Asserting reset in a WAIT cycle produces no response.
